// File: rtl/input_ctrl.sv
// ---------------------------------------------------------------------------
// input_ctrl -- AXI4-Stream frame loader in front of the FFT calc engine.
//
// Receives one frame of 2^LOG2N complex samples ({imag, real}) over AXIS,
// stores them in an internal frame RAM, pulses load_done after the last
// sample, then holds the frame and serves two independent 1-cycle-latency
// reads to the calc engine until calc_done releases the buffer.
//
// Build option:
//   INPUT_CTRL_BITREV_EN  defined   -> samples are written at bit-reversed
//                                      addresses (natural-order DIT output)
//                         undefined -> samples are written in arrival order
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_start      pulse: arm reception of one frame (ignored while busy)
//   calc_done       pulse: release the held frame (ignored in IDLE)
//   load_done       pulse: last sample of the frame has been written
//   busy            high while loading or holding a frame
//   frame_err       sticky: tlast did not line up with the sample count
//   s_axis_*        AXI4-Stream slave (tvalid/tready/tdata/tlast)
//   rd_idx1/rd_idx2 calc-engine read addresses
//   rd_x1/rd_x2     registered read data, one cycle after the address
// ---------------------------------------------------------------------------
module input_ctrl #(
  parameter int DATA_W = 64,
  parameter int LOG2N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              calc_done,
  output logic              load_done,
  output logic              busy,
  output logic              frame_err,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [LOG2N-1:0]  rd_idx1,
  input  logic [LOG2N-1:0]  rd_idx2,
  output logic [DATA_W-1:0] rd_x1,
  output logic [DATA_W-1:0] rd_x2
);

  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_r;
  logic [LOG2N-1:0]  wr_cnt_r;
  logic [LOG2N-1:0]  wr_addr_s;
  logic              beat_s;
  logic              last_s;
  logic [DATA_W-1:0] ram_r [0:(1<<LOG2N)-1];

`ifdef INPUT_CTRL_BITREV_EN
  // Mirror the address bits: bit i of the count becomes bit LOG2N-1-i.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = {LOG2N{1'b0}};
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction
`endif

  // Handshake decode and write-address generation.
  always_comb begin
    beat_s = 1'b0;
    last_s = 1'b0;
    if ((state_r == LOAD) && s_axis_tvalid && s_axis_tready) begin
      beat_s = 1'b1;
      last_s = (wr_cnt_r == LAST_IDX);
    end else begin
      beat_s = 1'b0;
      last_s = 1'b0;
    end
`ifdef INPUT_CTRL_BITREV_EN
    wr_addr_s = bitrev(wr_cnt_r);
`else
    wr_addr_s = wr_cnt_r;
`endif
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      s_axis_tready <= 1'b0;
      load_done     <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
      wr_cnt_r      <= {LOG2N{1'b0}};
    end else begin
      load_done <= 1'b0;
      case (state_r)
        IDLE: begin
          // calc_done has no meaning here and is deliberately not decoded.
          if (load_start) begin
            state_r       <= LOAD;
            s_axis_tready <= 1'b1;
            busy          <= 1'b1;
            frame_err     <= 1'b0;
            wr_cnt_r      <= {LOG2N{1'b0}};
          end
        end
        LOAD: begin
          if (beat_s) begin
            // tlast must appear exactly on the final count; the frame length
            // is fixed, so a misplaced tlast only flags, never truncates.
            if (s_axis_tlast != last_s) begin
              frame_err <= 1'b1;
            end
            if (last_s) begin
              state_r       <= HOLD;
              s_axis_tready <= 1'b0;
              load_done     <= 1'b1;
              wr_cnt_r      <= {LOG2N{1'b0}};
            end else begin
              wr_cnt_r <= wr_cnt_r + LOG2N'(1);
            end
          end
        end
        HOLD: begin
          // calc_done wins over a simultaneous load_start.
          if (calc_done) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          s_axis_tready <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  // Frame RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      ram_r[wr_addr_s] <= s_axis_tdata;
    end
  end

  // Two registered read ports, updated every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x1 <= {DATA_W{1'b0}};
      rd_x2 <= {DATA_W{1'b0}};
    end else begin
      rd_x1 <= ram_r[rd_idx1];
      rd_x2 <= ram_r[rd_idx2];
    end
  end

endmodule
